ctrl_pipe: RTL and testbench

//  Registered RV32I instruction-decode stage: decodes a fetched instruction into the core control bundle.

---
 rtl/ctrl_pkg.sv | 107 ++++++++++
 rtl/ctrl_dec.sv | 130 +++++++++++++
 rtl/ctrl_pipe.sv | 132 +++++++++++++
 tb/tb_ctrl_pipe.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the RV32I decode stage.
//   ALU_*, EXT_*, NPC_*, WDSEL_*, DM_* control codes, SCAUSE_* trap causes,
//   major opcodes, the packed control bundle (bit 31 = reg_write ... bit 0 = rs1[0])
//   and the trap FSM state encoding.
// Optional feature macro: CTRL_RV32M_EN (M-extension codes ALU_MUL..ALU_REMU).
package ctrl_pkg;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_LUI  = 5'd10;
    localparam logic [4:0] ALU_MUL  = 5'b11000;
    localparam logic [4:0] ALU_REMU = 5'b11111;

    // Immediate formats are one-hot so execute can select with a simple AND-OR.
    localparam logic [5:0] EXT_NONE  = 6'b000000;
    localparam logic [5:0] EXT_I     = 6'b000001;
    localparam logic [5:0] EXT_S     = 6'b000010;
    localparam logic [5:0] EXT_B     = 6'b000100;
    localparam logic [5:0] EXT_U     = 6'b001000;
    localparam logic [5:0] EXT_J     = 6'b010000;
    localparam logic [5:0] EXT_SHAMT = 6'b100000;

    localparam logic [2:0] NPC_PLUS4  = 3'd0;
    localparam logic [2:0] NPC_BRANCH = 3'd1;
    localparam logic [2:0] NPC_JAL    = 3'd2;
    localparam logic [2:0] NPC_JALR   = 3'd3;
    localparam logic [2:0] NPC_MRET   = 3'd4;

    localparam logic [1:0] WDSEL_ALU = 2'd0;
    localparam logic [1:0] WDSEL_MEM = 2'd1;
    localparam logic [1:0] WDSEL_PC4 = 2'd2;

    // Memory access types follow load/store funct3; 3'd3 is unused by RV32I.
    localparam logic [2:0] DM_B    = 3'd0;
    localparam logic [2:0] DM_H    = 3'd1;
    localparam logic [2:0] DM_W    = 3'd2;
    localparam logic [2:0] DM_NONE = 3'd3;
    localparam logic [2:0] DM_BU   = 3'd4;
    localparam logic [2:0] DM_HU   = 3'd5;

    localparam logic [7:0] SCAUSE_NOP     = 8'h00;
    localparam logic [7:0] SCAUSE_ILLEGAL = 8'h02;
    localparam logic [7:0] SCAUSE_ECALL   = 8'h0B;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;
    localparam logic [31:0] INSTR_MRET  = 32'h3020_0073;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic [5:0] ext_op;
        logic [4:0] alu_op;
        logic [2:0] npc_op;
        logic [1:0] wd_sel;
        logic [2:0] dm_type;
        logic [4:0] rd;
        logic [4:0] rs1;
    } ctrl_t;

    typedef enum logic {
        ST_RUN       = 1'b0,
        ST_TRAP_WAIT = 1'b1
    } state_t;

    // Bundle of an instruction with no side effects (also the bubble).
    function automatic ctrl_t ctrl_default();
        ctrl_t c;
        c         = '0;
        c.dm_type = DM_NONE;
        return c;
    endfunction

    // Register-register ALU op from funct3; alt selects SUB/SRA.
    function automatic logic [4:0] alu_rr(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_dec.sv
// ctrl_dec: purely combinational RV32I decoder.
//   instr      in  32  instruction word
//   ctrl       out 32  decoded control bundle (ctrl_t)
//   is_ecall   out 1   instruction is ecall
//   is_illegal out 1   encoding not supported
// CTRL_RV32M_EN defined: funct7=0000001 on OP is decoded as MUL..REMU; otherwise illegal.
import ctrl_pkg::*;

module ctrl_dec (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        is_ecall,
    output logic        is_illegal
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign funct7 = instr[31:25];

    always_comb begin
        ctrl       = ctrl_default();
        is_ecall   = 1'b0;
        is_illegal = 1'b0;
        // The all-zero word is a bubble and keeps the default bundle.
        if (instr != 32'h0) begin
            case (opcode)
                OPC_OP: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.rd        = rd;
                    ctrl.rs1       = rs1;
                    if (funct7 == 7'b0000000)
                        ctrl.alu_op = alu_rr(funct3, 1'b0);
                    else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
                        ctrl.alu_op = alu_rr(funct3, 1'b1);
`ifdef CTRL_RV32M_EN
                    else if (funct7 == 7'b0000001)
                        ctrl.alu_op = {2'b11, funct3};
`endif
                    else
                        is_illegal = 1'b1;
                end
                OPC_OPIMM: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.ext_op    = EXT_I;
                    ctrl.rd        = rd;
                    ctrl.rs1       = rs1;
                    if (funct3 == 3'b001) begin
                        ctrl.ext_op = EXT_SHAMT;
                        ctrl.alu_op = ALU_SLL;
                        is_illegal  = (funct7 != 7'b0000000);
                    end else if (funct3 == 3'b101) begin
                        ctrl.ext_op = EXT_SHAMT;
                        ctrl.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                        is_illegal  = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    end else begin
                        ctrl.alu_op = alu_rr(funct3, 1'b0);
                    end
                end
                OPC_LOAD: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.ext_op    = EXT_I;
                    ctrl.wd_sel    = WDSEL_MEM;
                    ctrl.dm_type   = funct3;
                    ctrl.rd        = rd;
                    ctrl.rs1       = rs1;
                    is_illegal     = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
                end
                OPC_STORE: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.ext_op    = EXT_S;
                    ctrl.dm_type   = funct3;
                    ctrl.rs1       = rs1;
                    is_illegal     = funct3[2] || (funct3 == 3'b011);
                end
                OPC_BRANCH: begin
                    ctrl.ext_op = EXT_B;
                    ctrl.npc_op = NPC_BRANCH;
                    ctrl.rs1    = rs1;
                    ctrl.alu_op = !funct3[2] ? ALU_SUB : (!funct3[1] ? ALU_SLT : ALU_SLTU);
                    is_illegal  = (funct3[2:1] == 2'b01);
                end
                OPC_JAL: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.ext_op    = EXT_J;
                    ctrl.npc_op    = NPC_JAL;
                    ctrl.wd_sel    = WDSEL_PC4;
                    ctrl.rd        = rd;
                end
                OPC_JALR: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.ext_op    = EXT_I;
                    ctrl.npc_op    = NPC_JALR;
                    ctrl.wd_sel    = WDSEL_PC4;
                    ctrl.rd        = rd;
                    ctrl.rs1       = rs1;
                    is_illegal     = (funct3 != 3'b000);
                end
                OPC_LUI, OPC_AUIPC: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.ext_op    = EXT_U;
                    ctrl.alu_op    = (opcode == OPC_LUI) ? ALU_LUI : ALU_ADD;
                    ctrl.rd        = rd;
                end
                OPC_SYSTEM: begin
                    if (instr == INSTR_ECALL)
                        is_ecall = 1'b1;
                    else if (instr == INSTR_MRET)
                        ctrl.npc_op = NPC_MRET;
                    else
                        is_illegal = 1'b1;
                end
                default: is_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: registered RV32I decode stage with a DEPTH-entry output queue
// and a trap FSM that stalls intake on ecall / illegal encodings.
//   clk, rstn                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_instr/in_pc   fetch side handshake
//   flush                          clears queue and pending trap
//   out_valid/out_ready/out_pc/out_ctrl  execute side handshake (queue head)
//   trap_valid/trap_cause/trap_pc/trap_ack  trap unit interface
// CTRL_RV32M_EN defined: M-extension encodings decoded (see ctrl_dec).
import ctrl_pkg::*;

module ctrl_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_ctrl,
    output logic            trap_valid,
    output logic [7:0]      trap_cause,
    output logic [XLEN-1:0] trap_pc,
    input  logic            trap_ack
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    ctrl_t           dec_ctrl_p0;
    logic            dec_ecall_p0;
    logic            dec_illegal_p0;
    logic            accept;
    logic            trap_hit;
    logic            push;
    logic            pop;

    state_t          state;
    logic [CW-1:0]   count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    ctrl_t           q_ctrl_p1 [DEPTH];
    logic [XLEN-1:0] q_pc_p1   [DEPTH];

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // ---- stage 0: combinational decode of the fetched word ----
    ctrl_dec u_dec (
        .instr      (in_instr),
        .ctrl       (dec_ctrl_p0),
        .is_ecall   (dec_ecall_p0),
        .is_illegal (dec_illegal_p0)
    );

    assign in_ready = (state == ST_RUN) && (count < CW'(DEPTH));
    assign accept   = in_valid && in_ready && !flush;
    assign trap_hit = accept && (dec_ecall_p0 || dec_illegal_p0);
    assign push     = accept && !trap_hit;
    assign pop      = out_valid && out_ready;

    // ---- stage 1: output queue ----
    // Entry storage is not reset; the head is masked while the queue is empty,
    // so stale words never reach out_pc/out_ctrl.
    always_ff @(posedge clk) begin
        if (push) begin
            q_ctrl_p1[wr_ptr] <= dec_ctrl_p0;
            q_pc_p1[wr_ptr]   <= in_pc;
        end
    end

    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? q_pc_p1[rd_ptr] : '0;
    assign out_ctrl  = out_valid ? q_ctrl_p1[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Trap FSM: a trapping instruction is held here, never enqueued.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_RUN;
            trap_valid <= 1'b0;
            trap_cause <= SCAUSE_NOP;
            trap_pc    <= '0;
        end else if (flush) begin
            state      <= ST_RUN;
            trap_valid <= 1'b0;
            trap_cause <= SCAUSE_NOP;
        end else begin
            case (state)
                ST_RUN: begin
                    if (trap_hit) begin
                        state      <= ST_TRAP_WAIT;
                        trap_valid <= 1'b1;
                        trap_cause <= dec_ecall_p0 ? SCAUSE_ECALL : SCAUSE_ILLEGAL;
                        trap_pc    <= in_pc;
                    end
                end
                default: begin
                    if (trap_ack) begin
                        state      <= ST_RUN;
                        trap_valid <= 1'b0;
                        trap_cause <= SCAUSE_NOP;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed scenarios plus randomized traffic checked against a
// queue-based reference model. Instructions are built from mnemonic fields
// together with their expected control bundle.
import ctrl_pkg::*;

module tb_ctrl_pipe;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_instr = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_ctrl;
    logic            trap_valid;
    logic [7:0]      trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic            trap_ack = 1'b0;

    int total = 0;
    int bad   = 0;

    ctrl_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_ctrl   (out_ctrl),
        .trap_valid (trap_valid),
        .trap_cause (trap_cause),
        .trap_pc    (trap_pc),
        .trap_ack   (trap_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Builds a random instruction and its expected result.
    // kind: 0 = enqueued, 1 = ecall, 2 = illegal.
    task automatic gen_instr(output logic [31:0] ins, output ctrl_t exp, output int kind);
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] r;
        logic [4:0]  rr_tab [8];
        logic [31:0] ill_tab [8];
        rr_tab  = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        ill_tab = '{32'hFFFF_FFFF, 32'h4000_1033, 32'h0000_3003, 32'h0000_7023,
                    32'h0000_2063, 32'h0000_1067, 32'h0010_0073, 32'h0200_1013};
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        r   = $urandom;
        exp = ctrl_default();
        kind = 0;
        case ($urandom_range(0, 12))
            0: begin
                f3  = 3'($urandom);
                alt = (f3 == 3'd0 || f3 == 3'd5) ? 1'($urandom) : 1'b0;
                ins = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, OPC_OP};
                exp.reg_write = 1'b1; exp.rd = rd; exp.rs1 = rs1;
                exp.alu_op = (alt && f3 == 3'd0) ? ALU_SUB : (alt ? ALU_SRA : rr_tab[f3]);
            end
            1: begin
                do f3 = 3'($urandom); while (f3 == 3'd1 || f3 == 3'd5);
                ins = {r[31:20], rs1, f3, rd, OPC_OPIMM};
                exp.reg_write = 1'b1; exp.alu_src = 1'b1; exp.ext_op = EXT_I;
                exp.rd = rd; exp.rs1 = rs1; exp.alu_op = rr_tab[f3];
            end
            2: begin
                f3  = r[0] ? 3'd5 : 3'd1;
                alt = (f3 == 3'd5) ? r[1] : 1'b0;
                ins = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, OPC_OPIMM};
                exp.reg_write = 1'b1; exp.alu_src = 1'b1; exp.ext_op = EXT_SHAMT;
                exp.rd = rd; exp.rs1 = rs1;
                exp.alu_op = (f3 == 3'd1) ? ALU_SLL : (alt ? ALU_SRA : ALU_SRL);
            end
            3: begin
                do f3 = 3'($urandom); while (f3 == 3'd3 || f3 >= 3'd6);
                ins = {r[31:20], rs1, f3, rd, OPC_LOAD};
                exp.reg_write = 1'b1; exp.alu_src = 1'b1; exp.ext_op = EXT_I;
                exp.wd_sel = WDSEL_MEM; exp.dm_type = f3; exp.rd = rd; exp.rs1 = rs1;
            end
            4: begin
                f3  = 3'($urandom_range(0, 2));
                ins = {r[31:25], rs2, rs1, f3, r[11:7], OPC_STORE};
                exp.mem_write = 1'b1; exp.alu_src = 1'b1; exp.ext_op = EXT_S;
                exp.dm_type = f3; exp.rs1 = rs1;
            end
            5: begin
                do f3 = 3'($urandom); while (f3 == 3'd2 || f3 == 3'd3);
                ins = {r[31:25], rs2, rs1, f3, r[11:7], OPC_BRANCH};
                exp.ext_op = EXT_B; exp.npc_op = NPC_BRANCH; exp.rs1 = rs1;
                exp.alu_op = (f3 < 3'd2) ? ALU_SUB : ((f3 < 3'd6) ? ALU_SLT : ALU_SLTU);
            end
            6: begin
                ins = {r[31:12], rd, OPC_JAL};
                exp.reg_write = 1'b1; exp.ext_op = EXT_J; exp.npc_op = NPC_JAL;
                exp.wd_sel = WDSEL_PC4; exp.rd = rd;
            end
            7: begin
                ins = {r[31:20], rs1, 3'b000, rd, OPC_JALR};
                exp.reg_write = 1'b1; exp.alu_src = 1'b1; exp.ext_op = EXT_I;
                exp.npc_op = NPC_JALR; exp.wd_sel = WDSEL_PC4; exp.rd = rd; exp.rs1 = rs1;
            end
            8: begin
                ins = {r[31:12], rd, r[0] ? OPC_LUI : OPC_AUIPC};
                exp.reg_write = 1'b1; exp.alu_src = 1'b1; exp.ext_op = EXT_U;
                exp.alu_op = r[0] ? ALU_LUI : ALU_ADD; exp.rd = rd;
            end
            9: begin
                case (r[1:0])
                    2'd0:    ins = 32'h0;
                    2'd1:    begin ins = INSTR_MRET; exp.npc_op = NPC_MRET; end
                    default: begin ins = INSTR_ECALL; kind = 1; end
                endcase
            end
            10: begin
                f3  = 3'($urandom);
                ins = {7'b0000001, rs2, rs1, f3, rd, OPC_OP};
`ifdef CTRL_RV32M_EN
                exp.reg_write = 1'b1; exp.rd = rd; exp.rs1 = rs1;
                exp.alu_op = ALU_MUL + 5'(f3);
`else
                kind = 2;
`endif
            end
            default: begin
                ins  = ill_tab[r[2:0]];
                kind = 2;
            end
        endcase
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) step();
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++;
        if (out_pc !== '0) begin bad++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
        total++;
        if (out_ctrl !== '0) begin bad++; $display("FAIL reset_out_ctrl got=%h exp=0", out_ctrl); end
        total++;
        if (trap_valid !== 1'b0 || trap_cause !== SCAUSE_NOP || trap_pc !== '0) begin
            bad++; $display("FAIL reset_trap got=%b/%h/%h exp=0/%h/0", trap_valid, trap_cause, trap_pc, SCAUSE_NOP);
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++;
        rstn = 1'b1;
        step();
    endtask

    task automatic test_add();
        ctrl_t c;
        in_valid = 1'b1; in_instr = 32'h0020_81B3; in_pc = 32'h100; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        c = ctrl_t'(out_ctrl);
        if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
            bad++; $display("FAIL add_head got=%b/%h exp=1/00000100", out_valid, out_pc);
        end
        total++;
        if (c.reg_write !== 1'b1 || c.alu_op !== ALU_ADD || c.rd !== 5'd3 || c.rs1 !== 5'd1) begin
            bad++; $display("FAIL add_ctrl got=%h exp=rw1 add rd3 rs1_1", out_ctrl);
        end
        total++;
        step();
        if (out_valid !== 1'b0) begin bad++; $display("FAIL add_pop got=%b exp=0", out_valid); end
        total++;
        out_ready = 1'b0;
    endtask

    task automatic test_fill_drain();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, in_ready); end
            total++;
            in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h300 + 32'(4 * i);
            step();
        end
        in_valid = 1'b0;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", in_ready); end
        total++;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (out_valid !== 1'b1 || out_pc !== 32'h300 + 32'(4 * i)) begin
                bad++; $display("FAIL drain_order[%0d] got=%b/%h exp=1/%h", i, out_valid, out_pc, 32'h300 + 32'(4 * i));
            end
            total++;
            if (in_ready !== (i != 0)) begin bad++; $display("FAIL drain_ready[%0d] got=%b exp=%b", i, in_ready, i != 0); end
            total++;
            step();
        end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
        total++;
        out_ready = 1'b0;
    endtask

    task automatic take_trap(input logic [31:0] ins, input logic [31:0] pc,
                             input logic [7:0] cause, input string nm);
        in_valid = 1'b1; in_instr = ins; in_pc = pc;
        step();
        in_valid = 1'b0;
        if (trap_valid !== 1'b1 || trap_cause !== cause || trap_pc !== pc) begin
            bad++; $display("FAIL %s_trap got=%b/%h/%h exp=1/%h/%h", nm, trap_valid, trap_cause, trap_pc, cause, pc);
        end
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL %s_stall got=rdy%b vld%b exp=rdy0 vld0", nm, in_ready, out_valid);
        end
        total++;
        step();
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        if (trap_valid !== 1'b0 || trap_cause !== SCAUSE_NOP || in_ready !== 1'b1) begin
            bad++; $display("FAIL %s_ack got=%b/%h/rdy%b exp=0/%h/rdy1", nm, trap_valid, trap_cause, in_ready, SCAUSE_NOP);
        end
        total++;
    endtask

    task automatic test_traps();
        take_trap(INSTR_ECALL, 32'h200, SCAUSE_ECALL, "ecall");
        take_trap(32'hFFFF_FFFF, 32'h204, SCAUSE_ILLEGAL, "ones");
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        if (trap_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL ack_in_run got=%b/rdy%b exp=0/rdy1", trap_valid, in_ready);
        end
        total++;
`ifdef CTRL_RV32M_EN
        begin
            ctrl_t c;
            in_valid = 1'b1; in_instr = 32'h0220_81B3; in_pc = 32'h208; out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            c = ctrl_t'(out_ctrl);
            if (out_valid !== 1'b1 || c.alu_op !== ALU_MUL || c.reg_write !== 1'b1 || trap_valid !== 1'b0) begin
                bad++; $display("FAIL mul got=%b/%h/trap%b exp=1/alu_mul/trap0", out_valid, out_ctrl, trap_valid);
            end
            total++;
            step();
            out_ready = 1'b0;
        end
`else
        take_trap(32'h0220_81B3, 32'h208, SCAUSE_ILLEGAL, "mul");
`endif
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h500 + 32'(4 * i);
            step();
        end
        in_valid = 1'b1; in_instr = INSTR_ECALL; in_pc = 32'h5F0;
        step();
        if (trap_valid !== 1'b1 || out_valid !== (DEPTH > 1)) begin
            bad++; $display("FAIL flush_setup got=%b/%b exp=1/%b", trap_valid, out_valid, DEPTH > 1);
        end
        total++;
        flush = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h5F4;
        step();
        flush = 1'b0; in_valid = 1'b0;
        if (out_valid !== 1'b0 || trap_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush got=vld%b trap%b rdy%b exp=vld0 trap0 rdy1", out_valid, trap_valid, in_ready);
        end
        total++;
        step();
        if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b exp=0", out_valid); end
        total++;
    endtask

    task automatic test_back_to_back();
        int head;
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h400;
        step();
        out_ready = 1'b1;
        head = 0;
        for (int k = 1; k <= 3 * DEPTH; k++) begin
            in_pc = 32'h400 + 32'(4 * k);
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_pc !== 32'h400 + 32'(4 * head)) begin
                bad++; $display("FAIL b2b[%0d] got=%b/%b/%h exp=1/1/%h", k, out_valid, in_ready, out_pc, 32'h400 + 32'(4 * head));
            end
            total++;
            step();
            head++;
        end
        in_valid = 1'b0;
        if (out_pc !== 32'h400 + 32'(4 * head)) begin
            bad++; $display("FAIL b2b_last got=%h exp=%h", out_pc, 32'h400 + 32'(4 * head));
        end
        total++;
        step();
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
        total++;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        ctrl_t       mq_ctrl [$];
        logic [31:0] mq_pc [$];
        logic        m_trap;
        logic [7:0]  m_cause;
        logic [31:0] m_tpc;
        logic        m_rdy;
        logic [31:0] ins;
        ctrl_t       ec;
        int          kind;
        m_trap = 1'b0; m_cause = SCAUSE_NOP; m_tpc = '0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            gen_instr(ins, ec, kind);
            in_instr  = ins;
            in_pc     = $urandom & 32'hFFFF_FFFC;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 49) == 0);
            trap_ack  = m_trap ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            m_rdy     = !m_trap && (mq_pc.size() < DEPTH);
            if (in_ready !== m_rdy) begin bad++; $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", cyc, in_ready, m_rdy); end
            total++;
            if (out_valid !== (mq_pc.size() != 0)) begin
                bad++; $display("FAIL rnd_out_valid[%0d] got=%b exp=%b", cyc, out_valid, mq_pc.size() != 0);
            end
            total++;
            if (mq_pc.size() != 0) begin
                if (out_pc !== mq_pc[0] || out_ctrl !== mq_ctrl[0]) begin
                    bad++; $display("FAIL rnd_head[%0d] got=%h/%h exp=%h/%h", cyc, out_pc, out_ctrl, mq_pc[0], mq_ctrl[0]);
                end
                total++;
            end
            if (trap_valid !== m_trap) begin bad++; $display("FAIL rnd_trap_valid[%0d] got=%b exp=%b", cyc, trap_valid, m_trap); end
            total++;
            if (m_trap) begin
                if (trap_cause !== m_cause || trap_pc !== m_tpc) begin
                    bad++; $display("FAIL rnd_trap[%0d] got=%h/%h exp=%h/%h", cyc, trap_cause, trap_pc, m_cause, m_tpc);
                end
                total++;
            end
            step();
            if (flush) begin
                mq_pc.delete(); mq_ctrl.delete();
                m_trap = 1'b0;
            end else begin
                if (mq_pc.size() != 0 && out_ready) begin
                    void'(mq_pc.pop_front()); void'(mq_ctrl.pop_front());
                end
                if (in_valid && m_rdy) begin
                    if (kind == 0) begin
                        mq_pc.push_back(in_pc); mq_ctrl.push_back(ec);
                    end else begin
                        m_trap  = 1'b1;
                        m_cause = (kind == 1) ? SCAUSE_ECALL : SCAUSE_ILLEGAL;
                        m_tpc   = in_pc;
                    end
                end else if (m_trap && trap_ack) begin
                    m_trap = 1'b0;
                end
            end
        end
        in_valid = 1'b0; trap_ack = 1'b0; out_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h600;
        step();
        in_instr = INSTR_ECALL; in_pc = 32'h604;
        step();
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        if (out_valid !== 1'b0 || out_pc !== '0 || out_ctrl !== '0) begin
            bad++; $display("FAIL midrst_out got=%b/%h/%h exp=0/0/0", out_valid, out_pc, out_ctrl);
        end
        total++;
        if (trap_valid !== 1'b0 || trap_cause !== SCAUSE_NOP || trap_pc !== '0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL midrst_trap got=%b/%h/%h/rdy%b exp=0/%h/0/rdy1", trap_valid, trap_cause, trap_pc, in_ready, SCAUSE_NOP);
        end
        total++;
        step();
        rstn = 1'b1;
        step();
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_after got=%b exp=0", out_valid); end
        total++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_fill_drain();
        test_traps();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1);
    end

endmodule
